osd_fade_sequencer: RTL and testbench

- Frame-synchronous controller for the OSD/scanline alpha blend stage.
- Owns the blend-stage configuration: the OSD background alpha, OSD visibility and scanline intensity.
- On OSD enable/disable it ramps the OSD background alpha between 0 and a programmed target over several frames.
- All configuration updates are applied only at frame start, so no visible frame tears mid-blend.

---
 rtl/osd_fade_sequencer_pkg.sv | 20 ++
 rtl/osd_fade_sequencer_ramp.sv | 30 +++
 rtl/osd_fade_sequencer.sv | 169 ++++++++++++++++
 tb/tb_osd_fade_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osd_fade_sequencer_pkg.sv
// Shared definitions for the OSD/scanline blend stage: alpha constants,
// fade state type and a saturating alpha clamp.
package osd_fade_sequencer_pkg;

  localparam logic [8:0] ONE_TO_ONE        = 9'd256;
  localparam logic [8:0] OSD_ALPHA_DEFAULT = 9'd64;

  typedef enum logic [1:0] {
    HIDDEN   = 2'd0,
    FADE_IN  = 2'd1,
    SHOWN    = 2'd2,
    FADE_OUT = 2'd3
  } osd_fade_state_e;

  function automatic logic [8:0] sat_alpha(input logic [9:0] value,
                                           input logic [8:0] limit);
    return (value > {1'b0, limit}) ? limit : value[8:0];
  endfunction

endpackage

// File: rtl/osd_fade_sequencer_ramp.sv
// Combinational saturating alpha step: moves the current alpha one step
// toward the target (up) or toward zero (down).
module alpha_ramp_step #(
  parameter logic [8:0] ONE_TO_ONE = 9'd256
) (
  input  logic [8:0] i_current,
  input  logic [8:0] i_target,
  input  logic [8:0] i_step,
  input  logic       i_dir_up,
  output logic [8:0] o_next
);
  import osd_fade_sequencer_pkg::*;

  logic [9:0] w_sum;
  logic [9:0] w_diff;
  logic [8:0] w_limit;

  always_comb begin
    w_sum   = {1'b0, i_current} + {1'b0, i_step};
    w_diff  = {1'b0, i_current} - {1'b0, i_step};
    w_limit = (i_target > ONE_TO_ONE) ? ONE_TO_ONE : i_target;
    if (i_dir_up) begin
      o_next = sat_alpha(w_sum, w_limit);
    end else begin
      // bit 9 set means the subtraction went below zero
      o_next = w_diff[9] ? '0 : sat_alpha(w_diff, ONE_TO_ONE);
    end
  end

endmodule

// File: rtl/osd_fade_sequencer.sv
// Frame-synchronous OSD fade controller: ramps OSD background alpha on
// enable/disable and applies scanline intensity updates at frame start.
module osd_fade_sequencer #(
  parameter int unsigned FRAMES_PER_STEP = 2,
  parameter logic [8:0]  ALPHA_STEP      = 9'd16,
  parameter logic [8:0]  ONE_TO_ONE      = 9'd256
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       frame_start,
  input  logic       osd_enable,
  input  logic [8:0] target_alpha,
  input  logic [8:0] scanline_intensity_in,
  input  logic       scanline_req,
  output logic       scanline_ack,
  output logic [8:0] osd_alpha,
  output logic       osd_visible,
  output logic [8:0] scanline_intensity,
  output logic       fade_busy
);
  import osd_fade_sequencer_pkg::*;

  localparam logic [3:0] FPS_CNT = 4'(FRAMES_PER_STEP);

  osd_fade_state_e r_state;
  osd_fade_state_e w_state_nxt;

  logic [8:0] r_alpha;
  logic [8:0] w_alpha_nxt;
  logic       r_visible;
  logic       w_visible_nxt;
  logic       r_busy;
  logic       w_busy_nxt;
  logic [3:0] r_frame_cnt;
  logic [3:0] w_frame_cnt_nxt;
  logic [3:0] w_frame_cnt_inc;
  logic [8:0] r_target;
  logic [8:0] w_target_in;
  logic [8:0] w_ramp_next;
  logic       w_step_due;
  logic       w_reverse;

  logic [8:0] r_hold;
  logic       r_pending;
  logic [8:0] r_intensity;
  logic       r_ack;
  logic       w_apply_scan;

  assign w_target_in     = sat_alpha({1'b0, target_alpha}, ONE_TO_ONE);
  assign w_frame_cnt_inc = r_frame_cnt + 4'd1;
  assign w_step_due      = (w_frame_cnt_inc == FPS_CNT);
  assign w_reverse       = ((r_state == FADE_IN)  && !osd_enable) ||
                           ((r_state == FADE_OUT) &&  osd_enable);
  assign w_apply_scan    = frame_start && (r_pending || scanline_req);

  alpha_ramp_step #(
    .ONE_TO_ONE (ONE_TO_ONE)
  ) u_ramp (
    .i_current (r_alpha),
    .i_target  (r_target),
    .i_step    (ALPHA_STEP),
    .i_dir_up  (r_state == FADE_IN),
    .o_next    (w_ramp_next)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= HIDDEN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (frame_start) begin
      unique case (r_state)
        HIDDEN:   if (osd_enable) w_state_nxt = FADE_IN;
        FADE_IN: begin
          if (!osd_enable)                              w_state_nxt = FADE_OUT;
          else if (w_step_due && w_ramp_next == r_target) w_state_nxt = SHOWN;
        end
        SHOWN:    if (!osd_enable) w_state_nxt = FADE_OUT;
        FADE_OUT: begin
          if (osd_enable)                         w_state_nxt = FADE_IN;
          else if (w_step_due && w_ramp_next == '0) w_state_nxt = HIDDEN;
        end
        default:  w_state_nxt = HIDDEN;
      endcase
    end
  end

  // Reversal only restarts the frame counter; alpha is never stepped on
  // the same frame the direction flips.
  always_comb begin
    w_alpha_nxt     = r_alpha;
    w_visible_nxt   = r_visible;
    w_frame_cnt_nxt = r_frame_cnt;
    w_busy_nxt      = r_busy;
    if (frame_start) begin
      w_busy_nxt = (w_state_nxt == FADE_IN) || (w_state_nxt == FADE_OUT);
      unique case (r_state)
        HIDDEN: begin
          w_frame_cnt_nxt = '0;
          if (osd_enable) w_visible_nxt = 1'b1;
        end
        SHOWN: begin
          w_frame_cnt_nxt = '0;
          if (osd_enable) w_alpha_nxt = w_target_in;
        end
        FADE_IN, FADE_OUT: begin
          if (w_reverse) begin
            w_frame_cnt_nxt = '0;
          end else if (w_step_due) begin
            w_frame_cnt_nxt = '0;
            w_alpha_nxt     = w_ramp_next;
            if ((r_state == FADE_OUT) && (w_ramp_next == '0)) begin
              w_visible_nxt = 1'b0;
            end
          end else begin
            w_frame_cnt_nxt = w_frame_cnt_inc;
          end
        end
        default: w_frame_cnt_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_alpha     <= '0;
      r_visible   <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_cnt <= '0;
      r_target    <= '0;
    end else begin
      r_alpha     <= w_alpha_nxt;
      r_visible   <= w_visible_nxt;
      r_busy      <= w_busy_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      if (frame_start) r_target <= w_target_in;
    end
  end

  // A request on the frame_start cycle bypasses the holding register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hold      <= '0;
      r_pending   <= 1'b0;
      r_intensity <= ONE_TO_ONE;
      r_ack       <= 1'b0;
    end else begin
      if (scanline_req) r_hold <= scanline_intensity_in;
      if (frame_start)       r_pending <= 1'b0;
      else if (scanline_req) r_pending <= 1'b1;
      r_ack <= w_apply_scan;
      if (w_apply_scan) begin
        r_intensity <= scanline_req ? scanline_intensity_in : r_hold;
      end
    end
  end

  assign osd_alpha          = r_alpha;
  assign osd_visible        = r_visible;
  assign fade_busy          = r_busy;
  assign scanline_intensity = r_intensity;
  assign scanline_ack       = r_ack;

endmodule

// File: tb/tb_osd_fade_sequencer.sv
// Self-checking bench for osd_fade_sequencer: directed fade scenarios plus
// randomized traffic against a frame-level behavioural model.
module tb_osd_fade_sequencer;

  localparam int FPS  = 2;
  localparam int STEP = 16;
  localparam int FULL = 256;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       osd_enable = 1'b0;
  logic [8:0] target_alpha = '0;
  logic [8:0] scanline_intensity_in = '0;
  logic       scanline_req = 1'b0;
  logic       scanline_ack;
  logic [8:0] osd_alpha;
  logic       osd_visible;
  logic [8:0] scanline_intensity;
  logic       fade_busy;

  int n_cmp = 0;
  int n_bad = 0;

  // model: m_dir = +1 fading in, -1 fading out, 0 steady (shown if m_vis)
  int m_alpha, m_target, m_frames, m_dir, m_int, m_hold;
  bit m_vis, m_pending, m_ack;

  always #5 clock = ~clock;

  osd_fade_sequencer #(
    .FRAMES_PER_STEP (FPS),
    .ALPHA_STEP      (9'd16),
    .ONE_TO_ONE      (9'd256)
  ) dut (
    .clock                 (clock),
    .reset_n               (reset_n),
    .frame_start           (frame_start),
    .osd_enable            (osd_enable),
    .target_alpha          (target_alpha),
    .scanline_intensity_in (scanline_intensity_in),
    .scanline_req          (scanline_req),
    .scanline_ack          (scanline_ack),
    .osd_alpha             (osd_alpha),
    .osd_visible           (osd_visible),
    .scanline_intensity    (scanline_intensity),
    .fade_busy             (fade_busy)
  );

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    m_alpha = 0; m_target = 0; m_frames = 0; m_dir = 0;
    m_int = FULL; m_hold = 0; m_vis = 0; m_pending = 0; m_ack = 0;
  endtask

  task automatic model_edge();
    int new_t;
    int old_t;
    m_ack = 0;
    if (scanline_req) begin
      m_hold = int'(scanline_intensity_in);
      m_pending = 1;
    end
    if (frame_start) begin
      if (m_pending) begin
        m_int = m_hold; m_pending = 0; m_ack = 1;
      end
      old_t = m_target;
      new_t = imin(int'(target_alpha), FULL);
      if (m_dir == 0 && !m_vis) begin
        if (osd_enable) begin m_vis = 1; m_dir = 1; m_frames = 0; end
      end else if (m_dir == 0) begin
        if (!osd_enable) begin m_dir = -1; m_frames = 0; end
        else m_alpha = new_t;
      end else if ((m_dir > 0) != osd_enable) begin
        m_dir = -m_dir; m_frames = 0;
      end else begin
        m_frames++;
        if (m_frames == FPS) begin
          m_frames = 0;
          if (m_dir > 0) begin
            m_alpha = imin(m_alpha + STEP, old_t);
            if (m_alpha == old_t) m_dir = 0;
          end else begin
            m_alpha = imax(m_alpha - STEP, 0);
            if (m_alpha == 0) begin m_dir = 0; m_vis = 0; end
          end
        end
      end
      m_target = new_t;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic frame(input int gap);
    repeat (gap - 1) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if (osd_alpha !== 9'd0) begin n_bad++; $display("FAIL reset_alpha: got %0d expected 0", osd_alpha); end
    n_cmp++; if (osd_visible !== 1'b0) begin n_bad++; $display("FAIL reset_visible: got %b expected 0", osd_visible); end
    n_cmp++; if (scanline_intensity !== 9'd256) begin n_bad++; $display("FAIL reset_intensity: got %0d expected 256", scanline_intensity); end
    n_cmp++; if (scanline_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b expected 0", scanline_ack); end
    n_cmp++; if (fade_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", fade_busy); end
    reset_n = 1'b1;
  endtask

  task automatic test_fade_in();
    int   exp_a [9] = '{0, 0, 16, 16, 32, 32, 48, 48, 64};
    logic exp_b;
    target_alpha = 9'd64;
    osd_enable = 1'b1;
    for (int f = 0; f < 9; f++) begin
      frame(3);
      exp_b = (f < 8);
      n_cmp++; if (osd_alpha !== 9'(exp_a[f])) begin n_bad++; $display("FAIL fade_in_alpha f%0d: got %0d expected %0d", f + 1, osd_alpha, exp_a[f]); end
      n_cmp++; if (osd_visible !== 1'b1) begin n_bad++; $display("FAIL fade_in_visible f%0d: got %b expected 1", f + 1, osd_visible); end
      n_cmp++; if (fade_busy !== exp_b) begin n_bad++; $display("FAIL fade_in_busy f%0d: got %b expected %b", f + 1, fade_busy, exp_b); end
    end
  endtask

  task automatic test_fade_out();
    int   exp_a [9] = '{64, 64, 48, 48, 32, 32, 16, 16, 0};
    logic exp_b;
    osd_enable = 1'b0;
    for (int f = 0; f < 9; f++) begin
      frame(3);
      exp_b = (f < 8);
      n_cmp++; if (osd_alpha !== 9'(exp_a[f])) begin n_bad++; $display("FAIL fade_out_alpha f%0d: got %0d expected %0d", f + 1, osd_alpha, exp_a[f]); end
      n_cmp++; if (osd_visible !== exp_b) begin n_bad++; $display("FAIL fade_out_visible f%0d: got %b expected %b", f + 1, osd_visible, exp_b); end
      n_cmp++; if (fade_busy !== exp_b) begin n_bad++; $display("FAIL fade_out_busy f%0d: got %b expected %b", f + 1, fade_busy, exp_b); end
    end
  endtask

  task automatic test_zero_target();
    target_alpha = 9'd0;
    osd_enable = 1'b1;
    frame(3);
    frame(3);
    n_cmp++; if (fade_busy !== 1'b1) begin n_bad++; $display("FAIL zero_busy_mid: got %b expected 1", fade_busy); end
    frame(3);
    n_cmp++; if (osd_alpha !== 9'd0) begin n_bad++; $display("FAIL zero_alpha: got %0d expected 0", osd_alpha); end
    n_cmp++; if (osd_visible !== 1'b1) begin n_bad++; $display("FAIL zero_visible: got %b expected 1", osd_visible); end
    n_cmp++; if (fade_busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy_done: got %b expected 0", fade_busy); end
    osd_enable = 1'b0;
    repeat (3) frame(3);
    n_cmp++; if (osd_visible !== 1'b0) begin n_bad++; $display("FAIL zero_hide_visible: got %b expected 0", osd_visible); end
    n_cmp++; if (fade_busy !== 1'b0) begin n_bad++; $display("FAIL zero_hide_busy: got %b expected 0", fade_busy); end
  endtask

  task automatic test_reversal();
    target_alpha = 9'd64;
    osd_enable = 1'b1;
    repeat (5) frame(3);
    n_cmp++; if (osd_alpha !== 9'd32) begin n_bad++; $display("FAIL rev_pre_alpha: got %0d expected 32", osd_alpha); end
    osd_enable = 1'b0;
    frame(3);
    n_cmp++; if (osd_alpha !== 9'd32) begin n_bad++; $display("FAIL rev_turn_alpha: got %0d expected 32", osd_alpha); end
    frame(3);
    n_cmp++; if (osd_alpha !== 9'd32) begin n_bad++; $display("FAIL rev_no_up_step: got %0d expected 32", osd_alpha); end
    frame(3);
    n_cmp++; if (osd_alpha !== 9'd16) begin n_bad++; $display("FAIL rev_down_step: got %0d expected 16", osd_alpha); end
    osd_enable = 1'b1;
    frame(3);
    frame(3);
    n_cmp++; if (osd_alpha !== 9'd16) begin n_bad++; $display("FAIL rev_back_hold: got %0d expected 16", osd_alpha); end
    n_cmp++; if (fade_busy !== 1'b1) begin n_bad++; $display("FAIL rev_back_busy: got %b expected 1", fade_busy); end
    frame(3);
    n_cmp++; if (osd_alpha !== 9'd32) begin n_bad++; $display("FAIL rev_back_up: got %0d expected 32", osd_alpha); end
    repeat (4) frame(3);
    n_cmp++; if (osd_alpha !== 9'd64) begin n_bad++; $display("FAIL rev_final_alpha: got %0d expected 64", osd_alpha); end
    n_cmp++; if (fade_busy !== 1'b0) begin n_bad++; $display("FAIL rev_final_busy: got %b expected 0", fade_busy); end
  endtask

  task automatic test_clamp();
    target_alpha = 9'd300;
    tick(); tick();
    n_cmp++; if (osd_alpha !== 9'd64) begin n_bad++; $display("FAIL clamp_pre: got %0d expected 64", osd_alpha); end
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    n_cmp++; if (osd_alpha !== 9'd256) begin n_bad++; $display("FAIL clamp_300: got %0d expected 256", osd_alpha); end
    target_alpha = 9'd200;
    tick(); tick();
    n_cmp++; if (osd_alpha !== 9'd256) begin n_bad++; $display("FAIL clamp_hold: got %0d expected 256", osd_alpha); end
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    n_cmp++; if (osd_alpha !== 9'd200) begin n_bad++; $display("FAIL clamp_200: got %0d expected 200", osd_alpha); end
  endtask

  task automatic test_scanline();
    scanline_req = 1'b1; scanline_intensity_in = 9'd128; tick();
    scanline_req = 1'b0; tick();
    scanline_req = 1'b1; scanline_intensity_in = 9'd192; tick();
    scanline_req = 1'b0; scanline_intensity_in = 9'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (scanline_intensity !== 9'd256) begin n_bad++; $display("FAIL scan_midframe: got %0d expected 256", scanline_intensity); end
      n_cmp++; if (scanline_ack !== 1'b0) begin n_bad++; $display("FAIL scan_midframe_ack: got %b expected 0", scanline_ack); end
    end
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    n_cmp++; if (scanline_intensity !== 9'd192) begin n_bad++; $display("FAIL scan_last_wins: got %0d expected 192", scanline_intensity); end
    n_cmp++; if (scanline_ack !== 1'b1) begin n_bad++; $display("FAIL scan_ack: got %b expected 1", scanline_ack); end
    tick();
    n_cmp++; if (scanline_ack !== 1'b0) begin n_bad++; $display("FAIL scan_ack_width: got %b expected 0", scanline_ack); end
    scanline_req = 1'b1; scanline_intensity_in = 9'd100; frame_start = 1'b1; tick();
    scanline_req = 1'b0; frame_start = 1'b0;
    n_cmp++; if (scanline_intensity !== 9'd100) begin n_bad++; $display("FAIL scan_coincide: got %0d expected 100", scanline_intensity); end
    n_cmp++; if (scanline_ack !== 1'b1) begin n_bad++; $display("FAIL scan_coincide_ack: got %b expected 1", scanline_ack); end
    scanline_req = 1'b1; scanline_intensity_in = 9'd77;
    for (int i = 0; i < 2; i++) begin
      frame(3);
      n_cmp++; if (scanline_ack !== 1'b1) begin n_bad++; $display("FAIL scan_level_ack%0d: got %b expected 1", i, scanline_ack); end
    end
    scanline_req = 1'b0;
    frame(3);
    n_cmp++; if (scanline_ack !== 1'b0) begin n_bad++; $display("FAIL scan_idle_ack: got %b expected 0", scanline_ack); end
    n_cmp++; if (scanline_intensity !== 9'd77) begin n_bad++; $display("FAIL scan_level_value: got %0d expected 77", scanline_intensity); end
  endtask

  task automatic test_reset_mid_fade();
    reset_n = 1'b0;
    model_reset();
    @(posedge clock); #1;
    reset_n = 1'b1;
    osd_enable = 1'b1;
    target_alpha = 9'd64;
    repeat (3) frame(3);
    n_cmp++; if (osd_alpha !== 9'd16) begin n_bad++; $display("FAIL midreset_pre: got %0d expected 16", osd_alpha); end
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (osd_alpha !== 9'd0) begin n_bad++; $display("FAIL midreset_alpha: got %0d expected 0", osd_alpha); end
    n_cmp++; if (osd_visible !== 1'b0) begin n_bad++; $display("FAIL midreset_visible: got %b expected 0", osd_visible); end
    n_cmp++; if (fade_busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %b expected 0", fade_busy); end
    n_cmp++; if (scanline_intensity !== 9'd256) begin n_bad++; $display("FAIL midreset_intensity: got %0d expected 256", scanline_intensity); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (osd_alpha !== 9'd0 || osd_visible !== 1'b0) begin n_bad++; $display("FAIL midreset_idle: got alpha %0d vis %b expected 0 0", osd_alpha, osd_visible); end
    end
    frame(1);
    n_cmp++; if (osd_visible !== 1'b1 || osd_alpha !== 9'd0) begin n_bad++; $display("FAIL midreset_restart: got alpha %0d vis %b expected 0 1", osd_alpha, osd_visible); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      frame_start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) osd_enable = ~osd_enable;
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 4))
          0:       target_alpha = 9'd0;
          1:       target_alpha = 9'd64;
          2:       target_alpha = 9'd256;
          3:       target_alpha = 9'd300;
          default: target_alpha = 9'($urandom_range(0, 511));
        endcase
      end
      scanline_req = ($urandom_range(0, 7) == 0);
      scanline_intensity_in = 9'($urandom_range(0, 256));
      tick();
      n_cmp++; if (osd_alpha !== 9'(m_alpha)) begin n_bad++; $display("FAIL rnd_alpha c%0d: got %0d expected %0d", i, osd_alpha, m_alpha); end
      n_cmp++; if (osd_visible !== m_vis) begin n_bad++; $display("FAIL rnd_visible c%0d: got %b expected %b", i, osd_visible, m_vis); end
      n_cmp++; if (fade_busy !== (m_dir != 0)) begin n_bad++; $display("FAIL rnd_busy c%0d: got %b expected %b", i, fade_busy, (m_dir != 0)); end
      n_cmp++; if (scanline_intensity !== 9'(m_int)) begin n_bad++; $display("FAIL rnd_intensity c%0d: got %0d expected %0d", i, scanline_intensity, m_int); end
      n_cmp++; if (scanline_ack !== m_ack) begin n_bad++; $display("FAIL rnd_ack c%0d: got %b expected %b", i, scanline_ack, m_ack); end
    end
    frame_start = 1'b0;
    scanline_req = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fade_in();
    test_fade_out();
    test_zero_target();
    test_reversal();
    test_clamp();
    test_scanline();
    test_reset_mid_fade();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
